// File: rtl/spi_ram_slave.sv
// SPI-slave memory access port: decodes 2-bit command frames and reads/writes an on-chip RAM.
// SPI lines are sampled on clk, one bit per rising edge while SS_n is low.
module spi_ram_slave #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_SIZE  = 8,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned AUTO_INC   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO,
    output logic frame_done,
    output logic frame_abort
);
    localparam int unsigned SH_W  = (DATA_WIDTH > ADDR_SIZE) ? DATA_WIDTH : ADDR_SIZE;
    localparam int unsigned CNT_W = $clog2(SH_W + 1);
    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned PW    = ADDR_SIZE + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_RX,
        S_RD_WAIT,
        S_TX,
        S_WAIT_END
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_cmd;
    logic [CNT_W-1:0]       r_cnt;
    logic [SH_W-1:0]        r_shift;
    logic [ADDR_SIZE-1:0]   r_wr_ptr;
    logic [ADDR_SIZE-1:0]   r_rd_ptr;
    logic                   r_miso;
    logic                   r_done;
    logic                   r_abort;
    logic [DATA_WIDTH-1:0]  r_mem [MEM_DEPTH];

    logic [SH_W-1:0]        w_rx_word;
    logic                   w_last_rx;
    logic                   w_mem_we;

    function automatic logic in_range(input logic [ADDR_SIZE-1:0] p);
        return {1'b0, p} < PW'(MEM_DEPTH);
    endfunction

    // In-range pointers wrap at MEM_DEPTH-1; out-of-range ones wrap naturally at 2**ADDR_SIZE.
    function automatic logic [ADDR_SIZE-1:0] ptr_next(input logic [ADDR_SIZE-1:0] p);
        if ({1'b0, p} == PW'(MEM_DEPTH - 1)) begin
            return '0;
        end
        return p + ADDR_SIZE'(1);
    endfunction

    assign w_rx_word = {r_shift[SH_W-2:0], MOSI};
    assign w_last_rx = (r_state == S_RX) && !SS_n && (r_cnt == CNT_W'(1));
    assign w_mem_we  = w_last_rx && (r_cmd == 2'b01) && in_range(r_wr_ptr);

    assign MISO        = r_miso;
    assign frame_done  = r_done;
    assign frame_abort = r_abort;

    // Storage is deliberately left out of reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[IDX_W'(r_wr_ptr)] <= w_rx_word[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cmd    <= '0;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_miso   <= 1'b0;
            r_done   <= 1'b0;
            r_abort  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_miso <= 1'b0;
                    if (!SS_n) begin
                        r_state <= S_CMD;
                        r_cnt   <= CNT_W'(2);
                    end
                end
                S_WAIT_END: begin
                    r_miso <= 1'b0;
                    if (SS_n) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    if (SS_n) begin
                        // Early deselect: discard the partial frame, touch nothing.
                        r_state <= S_IDLE;
                        r_abort <= 1'b1;
                        r_miso  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        case (r_state)
                            S_CMD: begin
                                r_cmd <= {r_cmd[0], MOSI};
                                r_cnt <= r_cnt - CNT_W'(1);
                                if (r_cnt == CNT_W'(1)) begin
                                    if ({r_cmd[0], MOSI} == 2'b11) begin
                                        r_state <= S_RD_WAIT;
                                    end else begin
                                        r_state <= S_RX;
                                        r_cnt   <= ({r_cmd[0], MOSI} == 2'b01) ? CNT_W'(DATA_WIDTH)
                                                                               : CNT_W'(ADDR_SIZE);
                                    end
                                end
                            end
                            S_RX: begin
                                r_shift <= w_rx_word;
                                r_cnt   <= r_cnt - CNT_W'(1);
                                if (r_cnt == CNT_W'(1)) begin
                                    case (r_cmd)
                                        2'b00:   r_wr_ptr <= w_rx_word[ADDR_SIZE-1:0];
                                        2'b01:   if (AUTO_INC != 0) r_wr_ptr <= ptr_next(r_wr_ptr);
                                        default: r_rd_ptr <= w_rx_word[ADDR_SIZE-1:0];
                                    endcase
                                    r_done  <= 1'b1;
                                    r_state <= S_WAIT_END;
                                end
                            end
                            S_RD_WAIT: begin
                                r_shift <= in_range(r_rd_ptr) ? SH_W'(r_mem[IDX_W'(r_rd_ptr)]) : '0;
                                r_cnt   <= CNT_W'(DATA_WIDTH);
                                r_state <= S_TX;
                            end
                            S_TX: begin
                                r_miso  <= r_shift[DATA_WIDTH-1];
                                r_shift <= r_shift << 1;
                                r_cnt   <= r_cnt - CNT_W'(1);
                                if (r_cnt == CNT_W'(1)) begin
                                    if (AUTO_INC != 0) begin
                                        r_rd_ptr <= ptr_next(r_rd_ptr);
                                    end
                                    r_done  <= 1'b1;
                                    r_state <= S_WAIT_END;
                                end
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_slave.sv
// Bench for spi_ram_slave: drives identical SPI traffic into an AUTO_INC=1 and an AUTO_INC=0
// instance and compares both against a word-level memory/pointer model.
module tb_spi_ram_slave;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic MOSI  = 1'b0;
    logic SS_n  = 1'b1;
    logic miso_inc, done_inc, abort_inc;
    logic miso_hold, done_hold, abort_hold;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_ram_slave #(.DATA_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(1)) u_inc (
        .clk(clk), .rst_n(rst_n), .MOSI(MOSI), .SS_n(SS_n),
        .MISO(miso_inc), .frame_done(done_inc), .frame_abort(abort_inc)
    );

    spi_ram_slave #(.DATA_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(0)) u_hold (
        .clk(clk), .rst_n(rst_n), .MOSI(MOSI), .SS_n(SS_n),
        .MISO(miso_hold), .frame_done(done_hold), .frame_abort(abort_hold)
    );

    // Index 0 = auto-increment instance, index 1 = pointer-hold instance.
    int pc_done  [2] = '{0, 0};
    int pc_abort [2] = '{0, 0};

    always @(negedge clk) begin
        if (done_inc === 1'b1)   pc_done[0]++;
        if (done_hold === 1'b1)  pc_done[1]++;
        if (abort_inc === 1'b1)  pc_abort[0]++;
        if (abort_hold === 1'b1) pc_abort[1]++;
    end

    logic [7:0] m_mem   [2][256];
    bit         m_known [2][256];
    logic [7:0] m_wr    [2];
    logic [7:0] m_rd    [2];
    logic [7:0] m_exp   [2];
    bit         m_exp_known [2];

    logic [7:0] obs_rx [2];
    logic [1:0] obs_done_end, obs_abort_end, obs_post;
    logic [3:0] obs_pre;
    int         d_done [2];
    int         d_abort [2];

    task automatic model_reset_ptrs();
        for (int i = 0; i < 2; i++) begin
            m_wr[i] = 8'h00;
            m_rd[i] = 8'h00;
        end
    endtask

    task automatic model_apply(input logic [1:0] cmd, input logic [7:0] pl);
        for (int i = 0; i < 2; i++) begin
            case (cmd)
                2'b00: m_wr[i] = pl;
                2'b01: begin
                    m_mem[i][m_wr[i]]   = pl;
                    m_known[i][m_wr[i]] = 1'b1;
                    if (i == 0) m_wr[i] = 8'((int'(m_wr[i]) + 1) % 256);
                end
                2'b10: m_rd[i] = pl;
                default: begin
                    m_exp[i]       = m_mem[i][m_rd[i]];
                    m_exp_known[i] = m_known[i][m_rd[i]];
                    if (i == 0) m_rd[i] = 8'((int'(m_rd[i]) + 1) % 256);
                end
            endcase
        end
    endtask

    // Drives one frame; abort_after >= 0 raises SS_n after that many payload bits (write-type frames).
    task automatic frame(input logic [1:0] cmd, input logic [7:0] pl, input int abort_after);
        int base_d [2];
        int base_a [2];
        base_d = pc_done;
        base_a = pc_abort;
        obs_pre = '0;
        obs_post = '0;
        @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
        @(negedge clk); MOSI = cmd[1];
        @(negedge clk); MOSI = cmd[0];
        if (cmd == 2'b11) begin
            @(negedge clk); obs_pre[3:2] = {miso_hold, miso_inc};
            @(negedge clk); obs_pre[1:0] = {miso_hold, miso_inc};
            for (int k = 7; k >= 0; k--) begin
                @(negedge clk);
                obs_rx[0][k] = miso_inc;
                obs_rx[1][k] = miso_hold;
            end
            obs_done_end  = {done_hold, done_inc};
            obs_abort_end = {abort_hold, abort_inc};
            SS_n = 1'b1;
            @(negedge clk); obs_post = {miso_hold, miso_inc};
            @(negedge clk);
        end else begin
            for (int b = 0; b < 8; b++) begin
                if (abort_after >= 0 && b == abort_after) break;
                @(negedge clk); MOSI = pl[7-b];
            end
            if (abort_after >= 0) begin
                @(negedge clk); SS_n = 1'b1;
                @(negedge clk);
                obs_done_end  = {done_hold, done_inc};
                obs_abort_end = {abort_hold, abort_inc};
            end else begin
                @(negedge clk);
                obs_done_end  = {done_hold, done_inc};
                obs_abort_end = {abort_hold, abort_inc};
                SS_n = 1'b1;
                @(negedge clk);
            end
            @(negedge clk);
        end
        MOSI = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d_done[i]  = pc_done[i] - base_d[i];
            d_abort[i] = pc_abort[i] - base_a[i];
        end
        if (abort_after < 0) model_apply(cmd, pl);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({miso_inc, done_inc, abort_inc, miso_hold, done_hold, abort_hold} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=000000",
                     {miso_inc, done_inc, abort_inc, miso_hold, done_hold, abort_hold});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset_ptrs();
        repeat (12) @(negedge clk);
        checks++;
        if (pc_done[0] + pc_done[1] + pc_abort[0] + pc_abort[1] != 0) begin
            failures++;
            $display("FAIL idle_pulses got=%0d exp=0", pc_done[0] + pc_done[1] + pc_abort[0] + pc_abort[1]);
        end
        checks++;
        if ({miso_inc, miso_hold} !== 2'b00) begin
            failures++;
            $display("FAIL idle_miso got=%b exp=00", {miso_inc, miso_hold});
        end
    endtask

    task automatic test_write_stream();
        logic [1:0] cmds [3] = '{2'b00, 2'b01, 2'b01};
        logic [7:0] pls  [3] = '{8'h10, 8'hA5, 8'h3C};
        for (int f = 0; f < 3; f++) begin
            frame(cmds[f], pls[f], -1);
            checks++;
            if (obs_done_end !== 2'b11 || obs_abort_end !== 2'b00) begin
                failures++;
                $display("FAIL write_done_edge frame=%0d done=%b abort=%b exp done=11 abort=00",
                         f, obs_done_end, obs_abort_end);
            end
            checks++;
            if (d_done[0] != 1 || d_done[1] != 1 || d_abort[0] != 0 || d_abort[1] != 0) begin
                failures++;
                $display("FAIL write_pulse_count frame=%0d done=%0d/%0d abort=%0d/%0d exp 1/1 0/0",
                         f, d_done[0], d_done[1], d_abort[0], d_abort[1]);
            end
        end
    endtask

    task automatic test_read_stream();
        logic [7:0] lit [2] = '{8'hA5, 8'h3C};
        frame(2'b10, 8'h10, -1);
        for (int r = 0; r < 2; r++) begin
            frame(2'b11, 8'h00, -1);
            for (int i = 0; i < 2; i++) begin
                if (m_exp_known[i]) begin
                    checks++;
                    if (obs_rx[i] !== m_exp[i]) begin
                        failures++;
                        $display("FAIL read_stream inst=%0d frame=%0d got=%h exp=%h", i, r, obs_rx[i], m_exp[i]);
                    end
                end
            end
            checks++;
            if (obs_rx[0] !== lit[r]) begin
                failures++;
                $display("FAIL read_stream_literal frame=%0d got=%h exp=%h", r, obs_rx[0], lit[r]);
            end
            checks++;
            if (obs_pre !== 4'b0 || obs_post !== 2'b0 || obs_done_end !== 2'b11) begin
                failures++;
                $display("FAIL read_latency frame=%0d pre=%b post=%b done=%b exp pre=0000 post=00 done=11",
                         r, obs_pre, obs_post, obs_done_end);
            end
        end
        // Pointers after the stream: writes land at wr_ptr, reads come from rd_ptr.
        frame(2'b01, 8'h5E, -1);
        frame(2'b11, 8'h00, -1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_rx[i] !== m_exp[i]) begin
                failures++;
                $display("FAIL pointer_after_stream inst=%0d got=%h exp=%h", i, obs_rx[i], m_exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] cmds [10] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11};
        logic [7:0] pls  [10] = '{8'h00, 8'h5A, 8'hFF, 8'h11, 8'h22, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int f = 0; f < 10; f++) begin
            frame(cmds[f], pls[f], -1);
            if (cmds[f] == 2'b11) begin
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (obs_rx[i] !== m_exp[i]) begin
                        failures++;
                        $display("FAIL wrap inst=%0d frame=%0d got=%h exp=%h", i, f, obs_rx[i], m_exp[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_abort();
        frame(2'b00, 8'h20, -1);
        frame(2'b01, 8'h44, -1);
        frame(2'b00, 8'h20, -1);
        frame(2'b01, 8'hE7, 5);
        checks++;
        if (obs_abort_end !== 2'b11 || obs_done_end !== 2'b00) begin
            failures++;
            $display("FAIL abort_edge abort=%b done=%b exp abort=11 done=00", obs_abort_end, obs_done_end);
        end
        checks++;
        if (d_abort[0] != 1 || d_abort[1] != 1 || d_done[0] != 0 || d_done[1] != 0) begin
            failures++;
            $display("FAIL abort_pulse_count abort=%0d/%0d done=%0d/%0d exp 1/1 0/0",
                     d_abort[0], d_abort[1], d_done[0], d_done[1]);
        end
        frame(2'b10, 8'h20, -1);
        frame(2'b11, 8'h00, -1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_rx[i] !== m_exp[i]) begin
                failures++;
                $display("FAIL abort_mem_kept inst=%0d got=%h exp=%h", i, obs_rx[i], m_exp[i]);
            end
        end
        frame(2'b01, 8'h77, -1);
        frame(2'b10, 8'h20, -1);
        frame(2'b11, 8'h00, -1);
        checks++;
        if (obs_rx[0] !== 8'h77 || obs_rx[1] !== m_exp[1]) begin
            failures++;
            $display("FAIL abort_then_write got=%h/%h exp=77/%h", obs_rx[0], obs_rx[1], m_exp[1]);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [3:0] got [2];
        logic [3:0] exp [2];
        frame(2'b10, 8'h10, -1);
        for (int i = 0; i < 2; i++) exp[i] = m_mem[i][m_rd[i]][7:4];
        @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
        @(negedge clk); MOSI = 1'b1;
        @(negedge clk); MOSI = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int k = 3; k >= 0; k--) begin
            @(negedge clk);
            got[0][k] = miso_inc;
            got[1][k] = miso_hold;
        end
        checks++;
        if (got[0] !== exp[0] || got[1] !== exp[1]) begin
            failures++;
            $display("FAIL midread_prefix got=%h/%h exp=%h/%h", got[0], got[1], exp[0], exp[1]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({miso_inc, done_inc, abort_inc, miso_hold, done_hold, abort_hold} !== 6'b0) begin
            failures++;
            $display("FAIL midread_reset_outputs got=%b exp=000000",
                     {miso_inc, done_inc, abort_inc, miso_hold, done_hold, abort_hold});
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        model_reset_ptrs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame(2'b11, 8'h00, -1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_rx[i] !== m_exp[i]) begin
                failures++;
                $display("FAIL midread_rdptr_zero inst=%0d got=%h exp=%h", i, obs_rx[i], m_exp[i]);
            end
        end
        frame(2'b10, 8'h10, -1);
        frame(2'b11, 8'h00, -1);
        checks++;
        if (obs_rx[0] !== 8'hA5 || obs_rx[1] !== m_exp[1]) begin
            failures++;
            $display("FAIL midread_mem_kept got=%h/%h exp=a5/%h", obs_rx[0], obs_rx[1], m_exp[1]);
        end
    endtask

    task automatic test_random();
        logic [1:0] cmd;
        logic [7:0] pl;
        int         ab;
        for (int n = 0; n < 40; n++) begin
            cmd = 2'($urandom_range(0, 3));
            pl  = 8'($urandom);
            if (cmd == 2'b10 && $urandom_range(0, 1) == 1) pl = 8'(int'(m_wr[0]) + 255);
            ab = (cmd != 2'b11 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
            frame(cmd, pl, ab);
            checks++;
            if (ab >= 0) begin
                if (d_abort[0] != 1 || d_abort[1] != 1 || d_done[0] != 0 || d_done[1] != 0) begin
                    failures++;
                    $display("FAIL random_abort n=%0d abort=%0d/%0d done=%0d/%0d exp 1/1 0/0",
                             n, d_abort[0], d_abort[1], d_done[0], d_done[1]);
                end
            end else if (d_done[0] != 1 || d_done[1] != 1 || d_abort[0] != 0 || d_abort[1] != 0) begin
                failures++;
                $display("FAIL random_done n=%0d done=%0d/%0d abort=%0d/%0d exp 1/1 0/0",
                         n, d_done[0], d_done[1], d_abort[0], d_abort[1]);
            end
            if (cmd == 2'b11) begin
                for (int i = 0; i < 2; i++) begin
                    if (m_exp_known[i]) begin
                        checks++;
                        if (obs_rx[i] !== m_exp[i]) begin
                            failures++;
                            $display("FAIL random_read n=%0d inst=%0d got=%h exp=%h", n, i, obs_rx[i], m_exp[i]);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_stream();
        test_read_stream();
        test_wrap();
        test_abort();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_ram_slave.md
Name: spi_ram_slave

Overview:
- Parametrised SPI-slave-with-memory block: one FSM decodes SPI frames and controls an on-chip RAM directly.
- Adds configurable data/address widths, independent write and read pointers, optional auto-increment for streaming, and defined abort handling.
- SPI lines are sampled in the system clock domain, one bit per clk while SS_n is low.
- Sits at the chip's SPI pins as a register/memory access port.

Parameters:
- DATA_WIDTH, 8, memory word width and data payload bits per frame
- ADDR_SIZE, 8, pointer width and address payload bits per frame
- MEM_DEPTH, 256, number of words; must be ≤ 2**ADDR_SIZE
- AUTO_INC, 1, 1 = pointer advances after each data frame; 0 = pointer holds

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- MOSI  in  1  serial data in, MSB first
- SS_n  in  1  active-low frame select
- MISO  out  1  serial data out, registered
- frame_done  out  1  one-cycle pulse when a frame completes its payload
- frame_abort  out  1  one-cycle pulse when SS_n rises before payload completes

Behaviour:
- Reset: state IDLE; MISO=0, frame_done=0, frame_abort=0; wr_ptr=0, rd_ptr=0; bit counter and shift registers 0. Memory contents not reset.
- Frame format: 2 command bits, then payload, MSB first.
  - 00 WR_ADDR: payload ADDR_SIZE bits, loaded into wr_ptr.
  - 01 WR_DATA: payload DATA_WIDTH bits, written to mem[wr_ptr].
  - 10 RD_ADDR: payload ADDR_SIZE bits, loaded into rd_ptr.
  - 11 RD_DATA: no MOSI payload; slave returns DATA_WIDTH bits on MISO.
- States: IDLE, CMD, RX, RD_WAIT, TX, WAIT_END.
- IDLE: the edge that samples SS_n=0 moves to CMD; no bit is captured on that edge.
- CMD: the next 2 edges capture command bits.
  - 0x/10 → RX, bit counter loaded with payload length.
  - 11 → RD_WAIT.
- RX: one MOSI bit per edge.
  - The edge capturing the last bit commits the action: pointer load, or memory write plus wr_ptr increment when AUTO_INC=1.
  - Same edge: frame_done pulses next cycle; state → WAIT_END.
- RD_WAIT: one edge; shift register loaded with mem[rd_ptr] (synchronous read); → TX.
- TX: for k=1..DATA_WIDTH, MISO after edge (load edge + k) carries bit DATA_WIDTH-k.
  - On the edge driving the last bit: rd_ptr increments when AUTO_INC=1, frame_done pulses, state → WAIT_END.
  - The following edge drives MISO=0.
- WAIT_END: MOSI ignored; MISO=0; SS_n=1 → IDLE.
- SS_n sampled high in CMD/RX/RD_WAIT/TX:
  - → IDLE, frame_abort pulses one cycle, MISO=0.
  - No memory write and no pointer change; partial payload discarded.
- SS_n high in WAIT_END or IDLE: no pulse.
- Pointer increment wraps to 0 when pointer = MEM_DEPTH-1 (power-of-two or not).
- Out-of-range address (pointer ≥ MEM_DEPTH, only reachable via WR_ADDR/RD_ADDR load): write dropped, read returns 0. The pointer still increments and wraps to 0 after MEM_DEPTH-1 only if it is in range; otherwise it increments modulo 2**ADDR_SIZE.
- frame_done and frame_abort are never high together.
- Asynchronous reset at any point, including mid-TX: outputs and pointers return to reset values immediately; memory retains contents.

Test Plan (DATA_WIDTH=8, ADDR_SIZE=8, MEM_DEPTH=256, AUTO_INC=1 unless noted):
1. Assert rst_n=0 with SS_n=1 → MISO=0, frame_done=0, frame_abort=0; after release, an idle SS_n=1 period produces no pulses.
2. Frames WR_ADDR 0x10, WR_DATA 0xA5, WR_DATA 0x3C (SS_n high between frames):
   - 3 frame_done pulses.
   - mem[0x10]=0xA5, mem[0x11]=0x3C, wr_ptr=0x12.
3. Then RD_ADDR 0x10 followed by two RD_DATA frames:
   - MISO streams 10100101 then 00111100.
   - First bit appears 2 edges after the second command bit edge.
   - rd_ptr=0x12.
4. Wrap: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22 → mem[0xFF]=0x11, mem[0x00]=0x22.
   - Repeat with AUTO_INC=0 → mem[0xFF]=0x22, mem[0x00] untouched.
5. Abort: WR_ADDR 0x20, then WR_DATA with SS_n raised after 5 payload bits:
   - frame_abort pulses once, no frame_done.
   - mem[0x20] unchanged, wr_ptr=0x20.
   - A full WR_DATA 0x77 then lands at 0x20.
6. Reset mid-read: drop rst_n during the 4th TX bit:
   - MISO=0 immediately, pointers 0, mem[0x10] still 0xA5.
   - A new RD_ADDR 0x10 / RD_DATA returns 0xA5.
